// File: rtl/entrada_decimal_pkg.sv
// entrada_decimal shared definitions:
// selector codes, default width, FSM states.
package entrada_decimal_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  localparam logic [1:0] ENTRADA = 2'b11;
  localparam logic [1:0] SAIDA   = 2'b10;

  typedef enum logic {
    ST_ENTRY = 1'b0,
    ST_VALID = 1'b1
  } state_e;

endpackage

// File: rtl/entrada_decimal_if.sv
// entrada_decimal value handshake:
// confirmed value offered to the input register.
interface entrada_decimal_if #(
  parameter int DATA_WIDTH = 16
);

  logic [DATA_WIDTH-1:0] value;
  logic                  value_valid;
  logic                  value_ready;

  modport master (
    output value,
    output value_valid,
    input  value_ready
  );

  modport slave (
    input  value,
    input  value_valid,
    output value_ready
  );

endinterface

// File: rtl/entrada_decimal_debounce_pulse.sv
// debounce_pulse: 2-FF sync, stability counter,
// one-cycle pulse on the debounced rising edge.
module debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DB_W            = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam logic [DB_W-1:0] LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic            level;
  logic [DB_W-1:0] cnt;

  // bring the raw button into the clock domain
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // flip level after an unbroken run of mismatches
  always_ff @(posedge clock) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= sync2;
        pulse <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/entrada_decimal.sv
// entrada_decimal: keypad decimal entry,
// acc = acc*10 + digit, offered via valid/ready.
module entrada_decimal
  import entrada_decimal_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int MAX_DIGITS      = 5,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DB_W            = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            digit_sw,
  input  logic                  btn_digit,
  input  logic                  btn_clear,
  input  logic                  btn_confirm,
  entrada_decimal_if.master     value_if,
  output logic [DATA_WIDTH-1:0] entry_value,
  output logic [2:0]            digit_count,
  output logic                  entry_error
);

  localparam int SW = DATA_WIDTH + 4;
  localparam logic [SW-1:0] MAX_SUM =
    {4'b0, {DATA_WIDTH{1'b1}}};
  localparam logic [2:0] MAXD = 3'(MAX_DIGITS);

  logic [3:0] dsw1;
  logic [3:0] dsw2;
  logic       p_dig;
  logic       p_clr;
  logic       p_conf;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] val_q, val_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [SW-1:0]         ext;
  logic [SW-1:0]         sum;

  debounce_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W(DB_W)
  ) u_db_dig (
    .clock(clock), .reset(reset),
    .btn(btn_digit), .pulse(p_dig)
  );

  debounce_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W(DB_W)
  ) u_db_clr (
    .clock(clock), .reset(reset),
    .btn(btn_clear), .pulse(p_clr)
  );

  debounce_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W(DB_W)
  ) u_db_conf (
    .clock(clock), .reset(reset),
    .btn(btn_confirm), .pulse(p_conf)
  );

  // digit switches share the button sync latency
  always_ff @(posedge clock) begin
    if (reset) begin
      dsw1 <= '0;
      dsw2 <= '0;
    end else begin
      dsw1 <= digit_sw;
      dsw2 <= dsw1;
    end
  end

  assign ext = {4'b0, acc_q};
  assign sum = (ext << 3) + (ext << 1)
             + SW'(dsw2);

  // next state and datapath, clear wins
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_ENTRY: begin
        if (p_clr) begin
          acc_d = '0;
          cnt_d = '0;
          err_d = 1'b0;
        end else if (p_conf) begin
          if (cnt_q != 3'd0) begin
            val_d   = acc_q;
            state_d = ST_VALID;
          end
        end else if (p_dig) begin
          if (dsw2 > 4'd9 || cnt_q == MAXD) begin
            err_d = 1'b1;
          end else if (sum > MAX_SUM) begin
            err_d = 1'b1;
          end else begin
            acc_d = sum[DATA_WIDTH-1:0];
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_VALID: begin
        if (value_if.value_ready || p_clr) begin
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_ENTRY;
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_ENTRY;
      acc_q   <= '0;
      val_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign value_if.value       = val_q;
  assign value_if.value_valid = (state_q == ST_VALID);
  assign entry_value          = acc_q;
  assign digit_count          = cnt_q;
  assign entry_error          = err_q;

endmodule
